rw_bank_scheduler: RTL
======================

# rw_bank_scheduler

Per-bank read/write command scheduler that sits between the front-end transaction controller's sixteen bank queues and the shared DRAM command path. Each cycle it grants at most one bank through a one-hot grant vector. It arbitrates round-robin within the current direction, groups reads and writes into bursts, and switches direction on write-occupancy watermarks. Every direction change inserts a fixed bus-turnaround gap.

## Interface

Parameters:
- NUM_BANKS, 16, number of bank queues arbitrated.
- CNT_W, 7, width of the write-occupancy count (queue depth 64).
- WR_HI, 48, write occupancy at or above which a read burst yields to writes.
- WR_LO, 16, write occupancy at or below which a write burst yields to pending reads.
- MIN_BURST, 4, minimum grants in a direction before a watermark switch is allowed.
- TURN_CYC, 2, idle cycles inserted on every direction change (≥1).

Ports:
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, asynchronous active-low reset.
- rd_req, in, NUM_BANKS, bit i set when bank i holds a ready read at its head.
- wr_req, in, NUM_BANKS, bit i set when bank i holds a ready write at its head.
- wr_count, in, CNT_W, total writes buffered in the front end.
- cmd_ready, in, 1, command path accepts a grant this cycle.
- grant_o, out, [0:NUM_BANKS-1], one-hot bank grant; bit i = bank i; registered.
- grant_valid, out, 1, grant_o is valid; registered.
- grant_type, out, r_type (types_def), read or write for the current grant; registered.
- mode_o, out, 2, current state encoding, for debug and visibility.

## Operation

- States: S_READ=0, S_WRITE=1, S_TURN_R2W=2, S_TURN_W2R=3. Reset state is S_READ.
- Registers:
  - rd_ptr and wr_ptr (log2 NUM_BANKS bits each).
  - burst_cnt, which saturates at MIN_BURST.
  - turn_cnt.
  - last_grant mask (NUM_BANKS bits).
- Eligibility: elig_rd = rd_req & ~last_grant and elig_wr = wr_req & ~last_grant. Masking last_grant stops a bank from being granted twice before its request drops.
- S_READ, evaluated in priority order each cycle:
  1. Switch condition true → go to S_TURN_R2W, load turn_cnt=TURN_CYC-1, no grant. Switch condition: (wr_count≥WR_HI and burst_cnt≥MIN_BURST) or (elig_rd==0 and wr_req!=0).
  2. Else, if cmd_ready and elig_rd!=0 → grant the first set bit of elig_rd searching upward from rd_ptr with wrap. Set rd_ptr=(k+1) mod NUM_BANKS and increment burst_cnt (saturating).
  3. Else → no grant.
- S_WRITE is symmetric. Switch condition: (wr_count≤WR_LO and rd_req!=0 and burst_cnt≥MIN_BURST) or (elig_wr==0 and rd_req!=0). The round-robin search uses wr_ptr.
- S_TURN_*: no grants. turn_cnt decrements each cycle. At 0, enter the target mode with burst_cnt=0 and last_grant=0.
- No requests of either type: stay in the current mode with no grant. Idle does not cause a turnaround.
- The watermark switch overrides pending requests in the current direction, subject only to MIN_BURST.
- The pointers are never reset on a mode change; fairness persists across bursts.
- wr_count is unsigned. Comparisons are full-width and never wrap.

## Timing

- Grant latency: inputs sampled at posedge N; grant_o, grant_valid and grant_type are valid for the cycle following posedge N.
- grant_valid is a single-cycle pulse per grant.
- Banks must drop or advance their request by the posedge after seeing the grant. The last_grant mask covers exactly that one cycle.
- cmd_ready low: no grant is issued and the pointers hold. Watermark and turnaround logic still advance.
- Turnaround gap: exactly TURN_CYC cycles with grant_valid=0 between the last grant of one direction and the first possible grant of the other. The cycle in which the switch is decided also carries no grant.
- Reset is asynchronous, active-low, and may be asserted mid-burst or mid-turnaround. It immediately forces:
  - grant_o=0, grant_valid=0, grant_type=read, mode_o=0;
  - all pointers, counters and last_grant to 0.
- After reset deassertion, the first grant can appear one cycle after the first posedge with requests present.

## Test plan

- Reset: assert rst low with requests present → all outputs 0, mode_o=0. Release → first read grant to bank 0 one cycle after first sampled request.
- Round-robin: rd_req=16'hFFFF held, cmd_ready=1, wr_count=0 → grants banks 0,1,…,15,0,… one per cycle, never the same bank twice in a row.
- Watermark switch: continuous reads, wr_count=48, wr_req=16'h00F0 → exactly 4 read grants, then 1 decision cycle plus 2 idle cycles, then write grants to banks 4,5,6,7.
- Return to reads: in S_WRITE, wr_count drops to 16 after at least 4 write grants with rd_req!=0 → switch to S_TURN_W2R, 2 idle cycles, then read grants resume from the saved rd_ptr.
- Backpressure: cmd_ready=0 for 5 cycles with rd_req=16'h0003 → no grant_valid. On cmd_ready=1, the grant goes to the bank at rd_ptr, not bank 0 if the pointer advanced earlier.
- Reset mid-turnaround: pull rst low during S_TURN_R2W → mode_o=0 immediately, no stray grant after release.

Source files
------------

// File: rtl/rw_bank_scheduler.sv
// -----------------------------------------------------------------------------
// rw_bank_scheduler
//
// Read/write command scheduler between the front-end bank queues and the
// shared DRAM command path. It issues at most one bank grant per cycle. It
// arbitrates round-robin within the current direction, groups reads and
// writes into bursts, and changes direction on write-occupancy watermarks.
// Every direction change inserts a fixed bus-turnaround gap.
//
// Ports
//   clk         : single clock, all state updates on posedge
//   rst         : asynchronous reset, active-low
//   rd_req      : bit i set when bank i has a ready read at its head
//   wr_req      : bit i set when bank i has a ready write at its head
//   wr_count    : total writes buffered in the front end (unsigned)
//   cmd_ready   : command path accepts a grant this cycle
//   grant_o     : one-hot bank grant, bit i = bank i (registered)
//   grant_valid : single-cycle pulse marking a valid grant (registered)
//   grant_type  : read or write for the current grant (registered)
//   mode_o      : current scheduler state, for debug visibility
// -----------------------------------------------------------------------------
package types_def;
  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type;
endpackage

module rw_bank_scheduler
  import types_def::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int CNT_W     = 7,
  parameter int WR_HI     = 48,
  parameter int WR_LO     = 16,
  parameter int MIN_BURST = 4,
  parameter int TURN_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] rd_req,
  input  logic [NUM_BANKS-1:0] wr_req,
  input  logic [CNT_W-1:0]     wr_count,
  input  logic                 cmd_ready,
  output logic [0:NUM_BANKS-1] grant_o,
  output logic                 grant_valid,
  output r_type                grant_type,
  output logic [1:0]           mode_o
);

  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BC_W  = (MIN_BURST > 0) ? $clog2(MIN_BURST + 1) : 1;
  localparam int TC_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MIN_BURST);
  localparam logic [TC_W-1:0] TURN_LD   = TC_W'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    S_READ     = 2'd0,
    S_WRITE    = 2'd1,
    S_TURN_R2W = 2'd2,
    S_TURN_W2R = 2'd3
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [BC_W-1:0]      burst_cnt;
  logic [TC_W-1:0]      turn_cnt;
  logic [NUM_BANKS-1:0] last_grant;

  logic [NUM_BANKS-1:0] elig_rd_p0;
  logic [NUM_BANKS-1:0] elig_wr_p0;
  logic [PTR_W-1:0]     rd_k_p0;
  logic [PTR_W-1:0]     wr_k_p0;
  logic                 burst_full_p0;
  logic                 wr_hi_hit_p0;
  logic                 wr_lo_hit_p0;
  logic                 rd_switch_p0;
  logic                 wr_switch_p0;

  // First set bit of vec, searching upward from ptr and wrapping.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_BANKS-1:0] vec,
                                                input logic [PTR_W-1:0]     ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      j   = (int'(ptr) + i) % NUM_BANKS;
      idx = PTR_W'(j);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] k);
    return PTR_W'((int'(k) + 1) % NUM_BANKS);
  endfunction

  function automatic logic [0:NUM_BANKS-1] grant_vec(input logic [PTR_W-1:0] k);
    logic [0:NUM_BANKS-1] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_BANKS-1:0] bank_mask(input logic [PTR_W-1:0] k);
    logic [NUM_BANKS-1:0] m;
    m    = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [BC_W-1:0] burst_sat_inc(input logic [BC_W-1:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + 1'b1;
  endfunction

  // Stage p0: eligibility, round-robin picks and direction-switch decisions
  // from the current inputs and state.
  always_comb begin
    // A bank granted last cycle may still show its old request; mask it out.
    elig_rd_p0    = rd_req & ~last_grant;
    elig_wr_p0    = wr_req & ~last_grant;
    rd_k_p0       = rr_pick(elig_rd_p0, rd_ptr);
    wr_k_p0       = rr_pick(elig_wr_p0, wr_ptr);
    burst_full_p0 = (burst_cnt >= BURST_MAX);
    // Compare at integer width so the watermarks never wrap against wr_count.
    wr_hi_hit_p0  = (int'(wr_count) >= WR_HI);
    wr_lo_hit_p0  = (int'(wr_count) <= WR_LO);
    rd_switch_p0  = (wr_hi_hit_p0 && burst_full_p0) ||
                    ((elig_rd_p0 == '0) && (wr_req != '0));
    wr_switch_p0  = (wr_lo_hit_p0 && (rd_req != '0) && burst_full_p0) ||
                    ((elig_wr_p0 == '0) && (rd_req != '0));
  end

  // Stage p1: registered state and grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_READ;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      burst_cnt   <= '0;
      turn_cnt    <= '0;
      last_grant  <= '0;
      grant_o     <= '0;
      grant_valid <= 1'b0;
      grant_type  <= R_READ;
    end else begin
      // Each grant is a one-cycle pulse, and the mask covers only the next cycle.
      grant_o     <= '0;
      grant_valid <= 1'b0;
      last_grant  <= '0;
      case (state)
        S_READ: begin
          if (rd_switch_p0) begin
            state    <= S_TURN_R2W;
            turn_cnt <= TURN_LD;
          end else if (cmd_ready && (elig_rd_p0 != '0)) begin
            grant_o     <= grant_vec(rd_k_p0);
            grant_valid <= 1'b1;
            grant_type  <= R_READ;
            last_grant  <= bank_mask(rd_k_p0);
            rd_ptr      <= ptr_inc(rd_k_p0);
            burst_cnt   <= burst_sat_inc(burst_cnt);
          end
        end
        S_WRITE: begin
          if (wr_switch_p0) begin
            state    <= S_TURN_W2R;
            turn_cnt <= TURN_LD;
          end else if (cmd_ready && (elig_wr_p0 != '0)) begin
            grant_o     <= grant_vec(wr_k_p0);
            grant_valid <= 1'b1;
            grant_type  <= R_WRITE;
            last_grant  <= bank_mask(wr_k_p0);
            wr_ptr      <= ptr_inc(wr_k_p0);
            burst_cnt   <= burst_sat_inc(burst_cnt);
          end
        end
        S_TURN_R2W: begin
          if (turn_cnt == '0) begin
            state     <= S_WRITE;
            burst_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        S_TURN_W2R: begin
          if (turn_cnt == '0) begin
            state     <= S_READ;
            burst_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: state <= S_READ;
      endcase
    end
  end

  assign mode_o = state;

endmodule
